// File: rtl/mul_float_pkg.sv
// mul_float_pkg: operand classification, exponent constants and flag bit positions
// shared by mul_float_core and mul_float_round.
package mul_float_pkg;

   typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_e;

   localparam int FLAG_INEXACT   = 0;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_INVALID   = 3;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_exp_max(input int exp_w);
      return (1 << exp_w) - 1;
   endfunction

   // Subnormals (exp==0) classify as zero, so denormal inputs are flushed.
   function automatic fp_class_e fp_class(input logic exp_zero, input logic exp_ones,
                                          input logic fract_zero);
      if (exp_zero) return FP_ZERO;
      if (exp_ones) return fract_zero ? FP_INF : FP_NAN;
      return FP_NORMAL;
   endfunction

endpackage

// File: rtl/mul_float_round.sv
// mul_float_round: combinational normalise, round-to-nearest-even, special-case select and pack.
// With MUL_FLOAT_CORE_FLAGS_EN defined it also produces {invalid, overflow, underflow, inexact}.
module mul_float_round
   import mul_float_pkg::*;
#(
   parameter int EXP_W   = 8,
   parameter int FRACT_W = 23
) (
   input  logic [2*FRACT_W+1:0]   prod,
   input  logic [EXP_W+1:0]       exp_in,
   input  logic                   sign,
   input  logic                   invalid,
   input  logic                   inf,
   input  logic                   zero,
   output logic [EXP_W+FRACT_W:0] result
`ifdef MUL_FLOAT_CORE_FLAGS_EN
   ,output logic [3:0]            flags
`endif
);
   localparam int PW = 2 * FRACT_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0] EXP_MAX = EW'(fp_exp_max(EXP_W));

   logic            hi, g, s, rnd, ovf, unf;
   logic [PW-2:0]   pn;
   logic [FRACT_W:0] fr;
   logic [EW-1:0]   e;

   always_comb begin
      hi  = prod[PW-1];
      // pn drops the leading one; the kept fraction sits at its top.
      pn  = hi ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
      g   = pn[PW-2-FRACT_W];
      s   = |pn[PW-3-FRACT_W:0];
      rnd = g & (s | pn[PW-1-FRACT_W]);
      fr  = {1'b0, pn[PW-2 -: FRACT_W]} + {{FRACT_W{1'b0}}, rnd};
      e   = exp_in + EW'(hi) + EW'(fr[FRACT_W]);
      ovf = !e[EW-1] && (e >= EXP_MAX);
      unf = e[EW-1] || (e == '0);

      result = {sign, e[EXP_W-1:0], fr[FRACT_W-1:0]};
      if (invalid)   result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRACT_W-1){1'b0}}};
      else if (inf)  result = {sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
      else if (zero) result = {sign, {(EXP_W+FRACT_W){1'b0}}};
      else if (ovf)  result = {sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
      else if (unf)  result = {sign, {(EXP_W+FRACT_W){1'b0}}};
   end

`ifdef MUL_FLOAT_CORE_FLAGS_EN
   always_comb begin
      flags = '0;
      if (invalid) begin
         flags[FLAG_INVALID] = 1'b1;
      end else if (!inf && !zero) begin
         flags[FLAG_OVERFLOW]  = ovf;
         flags[FLAG_UNDERFLOW] = unf;
         flags[FLAG_INEXACT]   = g | s | ovf | unf;
      end
   end
`endif

endmodule

// File: rtl/mul_float_core.sv
// mul_float_core: pipelined float multiplier (capture, unpack, multiply, round/pack), latency 3.
// Define MUL_FLOAT_CORE_FLAGS_EN to add registered exception flags on oDATA_FLAGS.
module mul_float_core
   import mul_float_pkg::*;
#(
   parameter int EXP_W   = 8,
   parameter int FRACT_W = 23,
   parameter int TAG_W   = 4
) (
   input  logic                   iCLOCK,
   input  logic                   inRESET,
   input  logic                   iRESET_SYNC,
   input  logic                   iDATA_REQ,
   output logic                   oDATA_BUSY,
   input  logic [EXP_W+FRACT_W:0] iDATA_A,
   input  logic [EXP_W+FRACT_W:0] iDATA_B,
   input  logic [TAG_W-1:0]       iDATA_TAG,
   output logic                   oDATA_VALID,
   input  logic                   iDATA_BUSY,
   output logic [EXP_W+FRACT_W:0] oDATA_RESULT,
   output logic [TAG_W-1:0]       oDATA_TAG
`ifdef MUL_FLOAT_CORE_FLAGS_EN
   ,output logic [3:0]            oDATA_FLAGS
`endif
);
   localparam int W  = 1 + EXP_W + FRACT_W;
   localparam int MW = FRACT_W + 1;
   localparam int PW = 2 * MW;
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

   // Accepted operands land in a capture rank so unpacking starts from flops.
   logic             in_vld_d, in_vld_q;
   logic [W-1:0]     in_a_d, in_a_q, in_b_d, in_b_q;
   logic [TAG_W-1:0] in_tag_d, in_tag_q;

   logic             s0_vld_d, s0_vld_q, s0_sign_d, s0_sign_q;
   logic             s0_nv_d, s0_nv_q, s0_inf_d, s0_inf_q, s0_zero_d, s0_zero_q;
   logic [MW-1:0]    s0_ma_d, s0_ma_q, s0_mb_d, s0_mb_q;
   logic [EW-1:0]    s0_e_d, s0_e_q;
   logic [TAG_W-1:0] s0_tag_d, s0_tag_q;

   logic             s1_vld_d, s1_vld_q, s1_sign_d, s1_sign_q;
   logic             s1_nv_d, s1_nv_q, s1_inf_d, s1_inf_q, s1_zero_d, s1_zero_q;
   logic [PW-1:0]    s1_p_d, s1_p_q;
   logic [EW-1:0]    s1_e_d, s1_e_q;
   logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

   logic             out_vld_d, out_vld_q;
   logic [W-1:0]     out_res_d, out_res_q, round_res;
   logic [TAG_W-1:0] out_tag_d, out_tag_q;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
   logic [3:0]       out_flags_d, out_flags_q, round_flags;
`endif

   fp_class_e cls_a, cls_b;

   assign oDATA_BUSY = iDATA_BUSY;

   always_comb begin
      cls_a = fp_class(in_a_q[W-2 -: EXP_W] == '0, &in_a_q[W-2 -: EXP_W], in_a_q[FRACT_W-1:0] == '0);
      cls_b = fp_class(in_b_q[W-2 -: EXP_W] == '0, &in_b_q[W-2 -: EXP_W], in_b_q[FRACT_W-1:0] == '0);

      in_vld_d = in_vld_q;   in_a_d = in_a_q;       in_b_d = in_b_q;     in_tag_d = in_tag_q;
      s0_vld_d = s0_vld_q;   s0_sign_d = s0_sign_q; s0_nv_d = s0_nv_q;   s0_inf_d = s0_inf_q;
      s0_zero_d = s0_zero_q; s0_ma_d = s0_ma_q;     s0_mb_d = s0_mb_q;   s0_e_d = s0_e_q;
      s0_tag_d = s0_tag_q;
      s1_vld_d = s1_vld_q;   s1_sign_d = s1_sign_q; s1_nv_d = s1_nv_q;   s1_inf_d = s1_inf_q;
      s1_zero_d = s1_zero_q; s1_p_d = s1_p_q;       s1_e_d = s1_e_q;     s1_tag_d = s1_tag_q;
      out_vld_d = out_vld_q; out_res_d = out_res_q; out_tag_d = out_tag_q;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
      out_flags_d = out_flags_q;
`endif

      if (!iDATA_BUSY) begin
         in_vld_d  = iDATA_REQ;
         in_a_d    = iDATA_A;
         in_b_d    = iDATA_B;
         in_tag_d  = iDATA_TAG;

         s0_vld_d  = in_vld_q;
         s0_sign_d = in_a_q[W-1] ^ in_b_q[W-1];
         s0_nv_d   = (cls_a == FP_NAN) || (cls_b == FP_NAN) ||
                     (cls_a == FP_ZERO && cls_b == FP_INF) || (cls_a == FP_INF && cls_b == FP_ZERO);
         s0_inf_d  = (cls_a == FP_INF) || (cls_b == FP_INF);
         s0_zero_d = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);
         s0_ma_d   = {1'b1, in_a_q[FRACT_W-1:0]};
         s0_mb_d   = {1'b1, in_b_q[FRACT_W-1:0]};
         s0_e_d    = {2'b00, in_a_q[W-2 -: EXP_W]} + {2'b00, in_b_q[W-2 -: EXP_W]} - BIAS;
         s0_tag_d  = in_tag_q;

         s1_vld_d  = s0_vld_q;  s1_sign_d = s0_sign_q; s1_nv_d = s0_nv_q;
         s1_inf_d  = s0_inf_q;  s1_zero_d = s0_zero_q; s1_e_d  = s0_e_q;
         s1_p_d    = PW'(s0_ma_q) * PW'(s0_mb_q);
         s1_tag_d  = s0_tag_q;

         out_vld_d = s1_vld_q;
         out_res_d = round_res;
         out_tag_d = s1_tag_q;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
         out_flags_d = round_flags;
`endif
      end

      if (iRESET_SYNC) begin
         in_vld_d = 1'b0;   in_a_d = '0;       in_b_d = '0;     in_tag_d = '0;
         s0_vld_d = 1'b0;   s0_sign_d = 1'b0;  s0_nv_d = 1'b0;  s0_inf_d = 1'b0;
         s0_zero_d = 1'b0;  s0_ma_d = '0;      s0_mb_d = '0;    s0_e_d = '0;   s0_tag_d = '0;
         s1_vld_d = 1'b0;   s1_sign_d = 1'b0;  s1_nv_d = 1'b0;  s1_inf_d = 1'b0;
         s1_zero_d = 1'b0;  s1_p_d = '0;       s1_e_d = '0;     s1_tag_d = '0;
         out_vld_d = 1'b0;  out_res_d = '0;    out_tag_d = '0;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
         out_flags_d = '0;
`endif
      end
   end

   mul_float_round #(.EXP_W(EXP_W), .FRACT_W(FRACT_W)) u_round (
      .prod    (s1_p_q),
      .exp_in  (s1_e_q),
      .sign    (s1_sign_q),
      .invalid (s1_nv_q),
      .inf     (s1_inf_q),
      .zero    (s1_zero_q),
      .result  (round_res)
`ifdef MUL_FLOAT_CORE_FLAGS_EN
      ,.flags  (round_flags)
`endif
   );

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         in_vld_q <= 1'b0;  in_a_q <= '0;       in_b_q <= '0;     in_tag_q <= '0;
         s0_vld_q <= 1'b0;  s0_sign_q <= 1'b0;  s0_nv_q <= 1'b0;  s0_inf_q <= 1'b0;
         s0_zero_q <= 1'b0; s0_ma_q <= '0;      s0_mb_q <= '0;    s0_e_q <= '0;   s0_tag_q <= '0;
         s1_vld_q <= 1'b0;  s1_sign_q <= 1'b0;  s1_nv_q <= 1'b0;  s1_inf_q <= 1'b0;
         s1_zero_q <= 1'b0; s1_p_q <= '0;       s1_e_q <= '0;     s1_tag_q <= '0;
         out_vld_q <= 1'b0; out_res_q <= '0;    out_tag_q <= '0;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
         out_flags_q <= '0;
`endif
      end else begin
         in_vld_q <= in_vld_d;   in_a_q <= in_a_d;       in_b_q <= in_b_d;     in_tag_q <= in_tag_d;
         s0_vld_q <= s0_vld_d;   s0_sign_q <= s0_sign_d; s0_nv_q <= s0_nv_d;   s0_inf_q <= s0_inf_d;
         s0_zero_q <= s0_zero_d; s0_ma_q <= s0_ma_d;     s0_mb_q <= s0_mb_d;   s0_e_q <= s0_e_d;
         s0_tag_q <= s0_tag_d;
         s1_vld_q <= s1_vld_d;   s1_sign_q <= s1_sign_d; s1_nv_q <= s1_nv_d;   s1_inf_q <= s1_inf_d;
         s1_zero_q <= s1_zero_d; s1_p_q <= s1_p_d;       s1_e_q <= s1_e_d;     s1_tag_q <= s1_tag_d;
         out_vld_q <= out_vld_d; out_res_q <= out_res_d; out_tag_q <= out_tag_d;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
         out_flags_q <= out_flags_d;
`endif
      end
   end

   assign oDATA_VALID  = out_vld_q;
   assign oDATA_RESULT = out_res_q;
   assign oDATA_TAG    = out_tag_q;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
   assign oDATA_FLAGS  = out_flags_q;
`endif

endmodule

// File: tb/tb_mul_float_core.sv
// tb_mul_float_core: directed and random checks of mul_float_core against an integer float model.
module tb_mul_float_core;

   localparam int BIAS = 127;
   localparam int EMAX = 255;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flags;
      logic [3:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, rst_sync = 1'b0;
   logic        req = 1'b0, busy = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [3:0]  tag = '0;
   logic        obusy, vld;
   logic [31:0] res;
   logic [3:0]  otag;

   logic        h_req = 1'b0, h_busy = 1'b0;
   logic [15:0] h_a = '0, h_b = '0;
   logic [3:0]  h_tag = '0;
   logic        h_obusy, h_vld;
   logic [15:0] h_res;
   logic [3:0]  h_otag;
`ifdef MUL_FLOAT_CORE_FLAGS_EN
   logic [3:0]  flags, h_flags;
`endif

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   logic        hold_v = 1'b0;
   logic [31:0] hold_res;
   logic [3:0]  hold_tag;

   always #5 clk = ~clk;

   mul_float_core #(.EXP_W(8), .FRACT_W(23), .TAG_W(4)) u_dut (
      .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
      .iDATA_REQ(req), .oDATA_BUSY(obusy), .iDATA_A(a), .iDATA_B(b), .iDATA_TAG(tag),
      .oDATA_VALID(vld), .iDATA_BUSY(busy), .oDATA_RESULT(res), .oDATA_TAG(otag)
`ifdef MUL_FLOAT_CORE_FLAGS_EN
      , .oDATA_FLAGS(flags)
`endif
   );

   mul_float_core #(.EXP_W(5), .FRACT_W(10), .TAG_W(4)) u_half (
      .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
      .iDATA_REQ(h_req), .oDATA_BUSY(h_obusy), .iDATA_A(h_a), .iDATA_B(h_b), .iDATA_TAG(h_tag),
      .oDATA_VALID(h_vld), .iDATA_BUSY(h_busy), .oDATA_RESULT(h_res), .oDATA_TAG(h_otag)
`ifdef MUL_FLOAT_CORE_FLAGS_EN
      , .oDATA_FLAGS(h_flags)
`endif
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   // Exact product held as an integer; rounding decided by comparing the remainder to half an ulp.
   function automatic exp_t ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
      exp_t r;
      int ex, ey, e, sh;
      longint unsigned p, q, rem, half;
      logic sgn, nx, ny, ix, iy, zx, zy, inexact;
      ex = int'(x[30:23]);  ey = int'(y[30:23]);
      sgn = x[31] ^ y[31];
      nx = (ex == EMAX) && (x[22:0] != 0);  ny = (ey == EMAX) && (y[22:0] != 0);
      ix = (ex == EMAX) && (x[22:0] == 0);  iy = (ey == EMAX) && (y[22:0] == 0);
      zx = (ex == 0);                       zy = (ey == 0);
      r.tag = t;
      r.flags = 4'b0000;
      if (nx || ny || (zx && iy) || (ix && zy)) begin
         r.res = 32'h7FC0_0000;
         r.flags = 4'b1000;
      end else if (ix || iy) begin
         r.res = {sgn, 8'hFF, 23'd0};
      end else if (zx || zy) begin
         r.res = {sgn, 31'd0};
      end else begin
         p = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
         sh = (p >= (64'd1 << 47)) ? 24 : 23;
         e = ex + ey - BIAS + (sh - 23);
         q = p >> sh;
         rem = p - (q << sh);
         half = 64'd1 << (sh - 1);
         inexact = (rem != 0);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
         end
         if (e >= EMAX) begin
            r.res = {sgn, 8'hFF, 23'd0};
            r.flags = 4'b0101;
         end else if (e <= 0) begin
            r.res = {sgn, 31'd0};
            r.flags = 4'b0011;
         end else begin
            r.res = {sgn, e[7:0], q[22:0]};
            r.flags = {3'b000, inexact};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rnd_op();
      int unsigned sel = $urandom_range(0, 9);
      logic [31:0] v = $urandom;
      if (sel < 5)       v[30:23] = 8'($urandom_range(90, 164));
      else if (sel == 5) v[30:23] = 8'($urandom_range(0, 2));
      else if (sel == 6) v[30:23] = 8'($urandom_range(252, 255));
      else if (sel == 7) v[30:23] = 8'($urandom_range(60, 67));
      else if (sel == 8) v[30:23] = 8'($urandom_range(186, 194));
      else               v[22:0]  = ($urandom_range(0, 1) == 1) ? 23'h7F_FFFF : 23'd0;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_exp(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t,
                            input logic [31:0] r, input logic [3:0] f);
      exp_t ex;
      req = 1'b1; a = x; b = y; tag = t; busy = 1'b0;
      ex.res = r; ex.flags = f; ex.tag = t;
      exp_q.push_back(ex);
      tick();
   endtask

   task automatic drive_rnd(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t,
                            input logic bsy);
      req = 1'b1; a = x; b = y; tag = t; busy = bsy;
      if (!bsy) exp_q.push_back(ref_mul(x, y, t));
      tick();
   endtask

   task automatic drain();
      int n = 0;
      req = 1'b0; busy = 1'b0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) tick();
   endtask

   task automatic latency_probe(input string name);
      int n = 0;
      req = 1'b0;
      while (!vld && n < 10) begin
         tick();
         n++;
      end
      chk(name, 64'(n), 64'd3);
   endtask

   // Scoreboard: a result is consumed at the edge where it is valid and not stalled.
   always @(negedge clk) begin
      exp_t ex;
      if (rst_n && vld) begin
         if (busy) begin
            if (hold_v) begin
               chk("stall_hold_res", res, hold_res);
               chk("stall_hold_tag", otag, hold_tag);
            end
            hold_v = 1'b1; hold_res = res; hold_tag = otag;
         end else begin
            hold_v = 1'b0;
            if (exp_q.size() == 0) begin
               chk("spurious_valid", vld, 1'b0);
            end else begin
               ex = exp_q.pop_front();
               chk("result", res, ex.res);
               chk("tag", otag, ex.tag);
`ifdef MUL_FLOAT_CORE_FLAGS_EN
               chk("flags", flags, ex.flags);
`endif
            end
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   initial begin
      logic [31:0] x, y;
      #12;
      chk("rst_valid", vld, 1'b0);
      chk("rst_result", res, 32'd0);
      chk("rst_tag", otag, 4'd0);
      chk("rst_busy_follow", obusy, busy);
      chk("rst_h_valid", h_vld, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      drive_exp(32'h3FC0_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 4'b0000);
      latency_probe("latency_first");
      drain();

      drive_exp(32'h3F80_0001, 32'h3F80_0001, 4'd1, 32'h3F80_0002, 4'b0001);
      drive_exp(32'h3F80_0000, 32'h3F80_0001, 4'd2, 32'h3F80_0001, 4'b0000);
      drive_exp(32'h0000_0000, 32'h7F80_0000, 4'd3, 32'h7FC0_0000, 4'b1000);
      drive_exp(32'hBF80_0000, 32'h7F80_0000, 4'd4, 32'hFF80_0000, 4'b0000);
      drive_exp(32'h7F00_0000, 32'h7F00_0000, 4'd6, 32'h7F80_0000, 4'b0101);
      drive_exp(32'h0080_0000, 32'h3F00_0000, 4'd7, 32'h0000_0000, 4'b0011);
      drain();

      for (int i = 0; i < 4; i++) drive_rnd(rnd_op(), rnd_op(), 4'(i), 1'b0);
      x = rnd_op(); y = rnd_op();
      for (int i = 0; i < 2; i++) begin
         req = 1'b1; a = x; b = y; tag = 4'd4; busy = 1'b1;
         #1;
         chk("busy_tracks_high", obusy, 1'b1);
         chk("stall_out_valid", vld, 1'b1);
         chk("stall_out_tag", otag, 4'd0);
         tick();
      end
      drive_rnd(x, y, 4'd4, 1'b0);
      chk("busy_tracks_low", obusy, 1'b0);
      drain();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            req = 1'b0;
            busy = ($urandom_range(0, 1) == 1);
            tick();
         end else begin
            drive_rnd(rnd_op(), rnd_op(), 4'($urandom), ($urandom_range(0, 3) == 0));
         end
      end
      drain();

      drive_rnd(rnd_op(), rnd_op(), 4'd9, 1'b0);
      req = 1'b0;
      tick();
      rst_sync = 1'b1;
      exp_q.delete();
      tick();
      rst_sync = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("sync_rst_no_valid", vld, 1'b0);
         tick();
      end

      for (int i = 0; i < 4; i++) drive_rnd(rnd_op(), rnd_op(), 4'(i + 8), 1'b0);
      req = 1'b0;
      chk("pre_arst_valid", vld, 1'b1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_valid", vld, 1'b0);
      chk("arst_result", res, 32'd0);
      chk("arst_tag", otag, 4'd0);
      tick();
      tick();
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive_exp(32'hC000_0000, 32'h4040_0000, 4'd11, 32'hC0C0_0000, 4'b0000);
      latency_probe("latency_after_reset");
      drain();

      h_req = 1'b1; h_a = 16'h3C00; h_b = 16'h4000; h_tag = 4'd1;
      tick();
      h_a = 16'h7BFF; h_tag = 4'd2;
      tick();
      h_req = 1'b0;
      tick();
      tick();
      chk("half_valid_1", h_vld, 1'b1);
      chk("half_result_1", h_res, 16'h4000);
      chk("half_tag_1", h_otag, 4'd1);
      tick();
      chk("half_valid_2", h_vld, 1'b1);
      chk("half_result_2", h_res, 16'h7C00);
      chk("half_tag_2", h_otag, 4'd2);
      chk("half_busy_follow", h_obusy, h_busy);
      tick();
      chk("half_idle", h_vld, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
